icache_rsp_router: RTL and testbench
====================================

// Module: icache_rsp_router
// PURPOSE
//   Return path for the icache miss arbiter. The arbiter issues one-hot grants
//   toward the shared refill port. This block records the winner of every accepted
//   issue in an in-order ID FIFO. It steers each multi-beat refill response back to
//   that requester, and it throttles the arbiter when DEPTH requests are outstanding.
// PARAMETERS
//   WIDTH   4    number of requesters (grant vector width)
//   DEPTH   4    max outstanding issued requests (ID FIFO entries, >=2)
//   DATA_W  64   refill beat width
// PORTS
//   clk           in   1            clock
//   rst           in   1            synchronous active-high reset
//   iss_vld       in   1            downstream request handshake fired this cycle
//   iss_grant     in   WIDTH        one-hot arbiter grant for that request
//   iss_allow     out  1            registered: count < DEPTH; arbiter ANDs into its vld
//   dn_rsp_vld    in   1            refill beat valid
//   dn_rsp_last   in   1            final beat of current refill
//   dn_rsp_data   in   DATA_W       refill beat data
//   dn_rsp_rdy    out  1            beat accepted when vld&rdy
//   up_rsp_vld    out  WIDTH        one-hot beat valid to owning requester
//   up_rsp_last   out  1            copy of dn_rsp_last
//   up_rsp_data   out  DATA_W       copy of dn_rsp_data (shared bus)
//   up_rsp_rdy    in   WIDTH        per-requester ready
//   outstanding   out  $clog2(DEPTH+1)  current FIFO occupancy
//   err_overflow  out  1            sticky: push attempted while full
//   err_grant     out  1            sticky: iss_vld with iss_grant not one-hot
// BEHAVIOUR
//   - FIFO storage: $clog2(WIDTH)-bit index per entry (one-hot -> binary encode on push).
//   - FIFO control: rd/wr pointers wrap modulo DEPTH, and DEPTH need not be a power of 2.
//     Count register drives full/empty.
//   - Reset: pointers=0, count=0.
//     Reset values: iss_allow=1, dn_rsp_rdy=0, up_rsp_vld=0, outstanding=0,
//     err_*=0. up_rsp_data/last carry the input values and are not reset.
//   - Push: iss_vld & !full.
//     * Push while full: ignored, sets err_overflow, FIFO unchanged.
//     * Non-one-hot grant (zero or multi-bit): sets err_grant, and the push is not
//       performed.
//   - Head: idx = fifo[rd_ptr], valid when !empty.
//   - Routing: combinational, 0-cycle latency.
//     * up_rsp_vld = (dn_rsp_vld & !empty) << idx.
//     * dn_rsp_rdy = !empty & up_rsp_rdy[idx].
//   - Empty: dn_rsp_vld while empty stalls (rdy=0, no up_rsp_vld) and is not an error.
//   - Beat handshake: dn_rsp_vld & dn_rsp_rdy.
//     * When dn_rsp_last is also set: pop the head (rd_ptr++, count--).
//     * Non-last beat: no state change.
//   - Same-cycle push and pop:
//     * Both take effect and count is unchanged.
//     * Full + pop + push: push still rejected (iss_allow registered, no bypass).
//     * Empty + push: response cannot use the new entry until the next cycle.
//   - iss_allow, outstanding: pure functions of the count register (no comb path from
//     inputs).
//   - Sticky errors clear only on rst.
//   - rst mid-refill: all state flushed in that cycle.
//     Any in-flight beats are dropped by the env; the block makes no recovery
//     attempt.
// TESTING
//   1. Single request: push grant 4'b0100, 4-beat rsp, rdy=all 1.
//      -> up_rsp_vld=4'b0100 each beat; pop on beat 4; outstanding 1->0.
//   2. Ordering: push 0001,1000,0010, rsps back-to-back.
//      -> beats routed to req0, req3, req1 in order; count 3->0.
//   3. Full/throttle, DEPTH=4: 4 pushes -> iss_allow=0 next cycle.
//      5th push same cycle as last-beat pop -> rejected, err_overflow=1, count=3 after.
//   4. Backpressure: owner up_rsp_rdy=0 for 3 cycles mid-refill.
//      -> dn_rsp_rdy=0, data held, no pop; resumes and completes when rdy=1.
//   5. Empty stall: dn_rsp_vld=1 with count=0 -> rdy=0, up_rsp_vld=0.
//      Push 0010 -> next cycle routes to req1.
//   6. Bad grant: iss_vld with 4'b0110 -> err_grant=1, count unchanged.
//      rst mid-refill -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/icache_rsp_router.sv
// Return path for the icache miss arbiter: records each issued grant in an in-order
// ID FIFO, steers refill beats back to the owner, and throttles issue when full.
module icache_rsp_router #(
  parameter int WIDTH  = 4,
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iss_vld,
  input  logic [WIDTH-1:0]           iss_grant,
  output logic                       iss_allow,
  input  logic                       dn_rsp_vld,
  input  logic                       dn_rsp_last,
  input  logic [DATA_W-1:0]          dn_rsp_data,
  output logic                       dn_rsp_rdy,
  output logic [WIDTH-1:0]           up_rsp_vld,
  output logic                       up_rsp_last,
  output logic [DATA_W-1:0]          up_rsp_data,
  input  logic [WIDTH-1:0]           up_rsp_rdy,
  output logic [$clog2(DEPTH+1)-1:0] outstanding,
  output logic                       err_overflow,
  output logic                       err_grant
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [IDX_W-1:0] fifo_mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] count;
  logic [IDX_W-1:0] grant_idx, head_idx;
  logic             full, empty, onehot, push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full   = (count == CNT_W'(DEPTH));
  assign empty  = (count == '0);
  assign onehot = (iss_grant != '0) && ((iss_grant & (iss_grant - WIDTH'(1))) == '0);

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (iss_grant[i]) grant_idx = i[IDX_W-1:0];
  end

  // Bad or rejected grants never enter the FIFO; they only raise sticky flags.
  assign push = iss_vld & ~full & onehot;
  assign pop  = dn_rsp_vld & dn_rsp_rdy & dn_rsp_last;

  assign head_idx   = fifo_mem[rd_ptr];
  assign dn_rsp_rdy = ~empty & up_rsp_rdy[head_idx];

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    assign up_rsp_vld[g] = dn_rsp_vld & ~empty & (head_idx == IDX_W'(g));
  end

  assign up_rsp_last = dn_rsp_last;
  assign up_rsp_data = dn_rsp_data;
  assign iss_allow   = ~full;
  assign outstanding = count;

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= grant_idx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      err_overflow <= 1'b0;
      err_grant    <= 1'b0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
      if (iss_vld & full)    err_overflow <= 1'b1;
      if (iss_vld & ~onehot) err_grant    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_icache_rsp_router.sv
// Directed bench for icache_rsp_router: ordering, throttle, backpressure, empty stall,
// bad grant and reset mid-refill, all against hand-computed values.
module tb_icache_rsp_router;
  localparam int WIDTH = 4, DEPTH = 4, DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_vld;
  logic [WIDTH-1:0]  iss_grant;
  logic              iss_allow;
  logic              dn_rsp_vld, dn_rsp_last, dn_rsp_rdy;
  logic [DATA_W-1:0] dn_rsp_data;
  logic [WIDTH-1:0]  up_rsp_vld, up_rsp_rdy;
  logic              up_rsp_last;
  logic [DATA_W-1:0] up_rsp_data;
  logic [2:0]        outstanding;
  logic              err_overflow, err_grant;

  int n_chk = 0, n_err = 0;

  icache_rsp_router #(.WIDTH(WIDTH), .DEPTH(DEPTH), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .iss_vld(iss_vld), .iss_grant(iss_grant), .iss_allow(iss_allow),
    .dn_rsp_vld(dn_rsp_vld), .dn_rsp_last(dn_rsp_last), .dn_rsp_data(dn_rsp_data),
    .dn_rsp_rdy(dn_rsp_rdy), .up_rsp_vld(up_rsp_vld), .up_rsp_last(up_rsp_last),
    .up_rsp_data(up_rsp_data), .up_rsp_rdy(up_rsp_rdy), .outstanding(outstanding),
    .err_overflow(err_overflow), .err_grant(err_grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [WIDTH-1:0] g);
    iss_vld = 1'b1; iss_grant = g;
    step();
    iss_vld = 1'b0; iss_grant = '0;
  endtask

  // Present one beat, check routing before the edge, then clock it.
  task automatic beat(input string tag, input logic [63:0] data, input logic last,
                      input logic [WIDTH-1:0] exp_vld, input logic exp_rdy);
    dn_rsp_vld = 1'b1; dn_rsp_data = data; dn_rsp_last = last;
    #1;
    chk({tag, "_vld"}, 64'(up_rsp_vld), 64'(exp_vld));
    chk({tag, "_rdy"}, 64'(dn_rsp_rdy), 64'(exp_rdy));
    chk({tag, "_data"}, up_rsp_data, data);
    chk({tag, "_last"}, 64'(up_rsp_last), 64'(last));
    step();
    dn_rsp_vld = 1'b0; dn_rsp_last = 1'b0;
  endtask

  initial begin
    rst = 1'b1; iss_vld = 1'b0; iss_grant = '0; dn_rsp_vld = 1'b0; dn_rsp_last = 1'b0;
    dn_rsp_data = '0; up_rsp_rdy = 4'hF;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_allow", 64'(iss_allow), 64'd1);
    chk("rst_rdy", 64'(dn_rsp_rdy), 64'd0);
    chk("rst_upvld", 64'(up_rsp_vld), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    chk("rst_errs", {62'd0, err_overflow, err_grant}, 64'd0);

    // single request, 4 beats to req2
    push(4'b0100);
    chk("t1_out1", 64'(outstanding), 64'd1);
    for (int b = 0; b < 4; b++) beat("t1", 64'h100 + 64'(b), b == 3, 4'b0100, 1'b1);
    chk("t1_out0", 64'(outstanding), 64'd0);

    // in-order routing of three 2-beat refills
    push(4'b0001); push(4'b1000); push(4'b0010);
    chk("t2_out3", 64'(outstanding), 64'd3);
    beat("t2a", 64'hA0, 1'b0, 4'b0001, 1'b1); beat("t2a", 64'hA1, 1'b1, 4'b0001, 1'b1);
    chk("t2_out2", 64'(outstanding), 64'd2);
    beat("t2b", 64'hB0, 1'b0, 4'b1000, 1'b1); beat("t2b", 64'hB1, 1'b1, 4'b1000, 1'b1);
    chk("t2_out1", 64'(outstanding), 64'd1);
    beat("t2c", 64'hC0, 1'b0, 4'b0010, 1'b1); beat("t2c", 64'hC1, 1'b1, 4'b0010, 1'b1);
    chk("t2_out0", 64'(outstanding), 64'd0);

    // fill, then a 5th push coinciding with a last-beat pop is still rejected
    push(4'b0001); push(4'b0010); push(4'b0100); push(4'b1000);
    chk("t3_allow0", 64'(iss_allow), 64'd0);
    chk("t3_out4", 64'(outstanding), 64'd4);
    iss_vld = 1'b1; iss_grant = 4'b0001;
    beat("t3p", 64'hD0, 1'b1, 4'b0001, 1'b1);
    iss_vld = 1'b0; iss_grant = '0;
    chk("t3_out3", 64'(outstanding), 64'd3);
    chk("t3_ovf", 64'(err_overflow), 64'd1);
    chk("t3_allow1", 64'(iss_allow), 64'd1);
    beat("t3d1", 64'hD1, 1'b1, 4'b0010, 1'b1);
    beat("t3d2", 64'hD2, 1'b1, 4'b0100, 1'b1);
    beat("t3d3", 64'hD3, 1'b1, 4'b1000, 1'b1);
    chk("t3_drained", 64'(outstanding), 64'd0);

    // owner backpressure mid-refill; last asserted while stalled must not pop
    push(4'b0100);
    beat("t4a", 64'hE0, 1'b0, 4'b0100, 1'b1);
    up_rsp_rdy = 4'b1011;
    for (int c = 0; c < 3; c++) begin
      beat("t4bp", 64'hE1, 1'b1, 4'b0100, 1'b0);
      chk("t4_hold", 64'(outstanding), 64'd1);
    end
    up_rsp_rdy = 4'hF;
    beat("t4z", 64'hE1, 1'b1, 4'b0100, 1'b1);
    chk("t4_out0", 64'(outstanding), 64'd0);

    // empty stall, then a push becomes routable only the following cycle
    dn_rsp_vld = 1'b1; dn_rsp_last = 1'b1; dn_rsp_data = 64'hF0;
    #1;
    chk("t5_stall_rdy", 64'(dn_rsp_rdy), 64'd0);
    chk("t5_stall_vld", 64'(up_rsp_vld), 64'd0);
    iss_vld = 1'b1; iss_grant = 4'b0010;
    #1;
    chk("t5_nobypass", 64'(up_rsp_vld), 64'd0);
    step();
    iss_vld = 1'b0; iss_grant = '0;
    chk("t5_errs", {62'd0, err_overflow, err_grant}, 64'h2);
    beat("t5r", 64'hF0, 1'b1, 4'b0010, 1'b1);
    chk("t5_out0", 64'(outstanding), 64'd0);

    // multi-bit grant: flagged, not pushed
    push(4'b0110);
    chk("t6_errg", 64'(err_grant), 64'd1);
    chk("t6_out", 64'(outstanding), 64'd0);

    // reset mid-refill flushes everything
    push(4'b1000);
    beat("t6a", 64'h55, 1'b0, 4'b1000, 1'b1);
    dn_rsp_vld = 1'b1; dn_rsp_data = 64'h56; rst = 1'b1;
    step();
    chk("t6_rst_out", 64'(outstanding), 64'd0);
    chk("t6_rst_allow", 64'(iss_allow), 64'd1);
    chk("t6_rst_upvld", 64'(up_rsp_vld), 64'd0);
    chk("t6_rst_rdy", 64'(dn_rsp_rdy), 64'd0);
    chk("t6_rst_errs", {62'd0, err_overflow, err_grant}, 64'd0);
    rst = 1'b0; dn_rsp_vld = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
